sipo_deserializer: RTL and testbench

Serial-in, parallel-out deserializer: the receive-side counterpart to the 4-bit parallel-in/serial-out shifter. It samples one serial bit per enabled clock, assembles WIDTH-bit words, and presents each completed word on a parallel output held by a valid/ready handshake. A sticky overrun flag reports words lost while the consumer stalls.

---
 rtl/sipo_deserializer_if.sv | 36 +++
 rtl/sipo_deserializer.sv | 120 ++++++++++++
 tb/tb_sipo_deserializer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// Bus between a serial producer / parallel consumer and the SIPO deserializer.
// The master drives serial data and the consumer handshake; the slave returns the word and status.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             d;
  logic             s_en;
  logic             clr;
  logic             q_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output d,
    output s_en,
    output clr,
    output q_ready,
    input  q,
    input  q_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  d,
    input  s_en,
    input  clr,
    input  q_ready,
    output q,
    output q_valid,
    output busy,
    output overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: assembles WIDTH-bit words from enabled serial bits
// and holds each finished word behind a valid/ready handshake, flagging dropped words.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  sipo_deserializer_if.slave   bus
);

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sh_shifted;
  logic [WIDTH-1:0] w_sh_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_q_valid_next;
  logic             w_overrun_next;
  logic             w_shift;
  logic             w_complete;
  logic             w_drain;
  logic             w_load;
  logic             w_drop;

  // The shifted value already contains the bit sampled on this edge, so it is the completed word.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sh_shifted = {r_sh[WIDTH-2:0], bus.d};
    end else begin : g_lsb_first
      assign w_sh_shifted = {bus.d, r_sh[WIDTH-1:1]};
    end
  endgenerate

  // Event decode: shifting, word completion, consumer drain, and load-versus-drop decision.
  always_comb begin
    w_shift    = bus.s_en & ~bus.clr;
    w_complete = w_shift & (r_cnt == CNT_LAST);
    w_drain    = r_q_valid & bus.q_ready;
    w_load     = w_complete & (~r_q_valid | bus.q_ready);
    w_drop     = w_complete & r_q_valid & ~bus.q_ready;
  end

  // Shift register and bit counter next state; clr wins over s_en and discards that bit.
  always_comb begin
    w_sh_next  = r_sh;
    w_cnt_next = r_cnt;
    if (bus.clr) begin
      w_sh_next  = '0;
      w_cnt_next = '0;
    end else if (bus.s_en) begin
      w_sh_next = w_sh_shifted;
      if (r_cnt == CNT_LAST) begin
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end else begin
      w_sh_next  = r_sh;
      w_cnt_next = r_cnt;
    end
  end

  // Output slot next state; a load on a draining edge keeps q_valid high with no bubble.
  always_comb begin
    w_q_next       = r_q;
    w_q_valid_next = r_q_valid;
    if (w_load) begin
      w_q_next       = w_sh_shifted;
      w_q_valid_next = 1'b1;
    end else if (w_drain) begin
      w_q_valid_next = 1'b0;
    end else begin
      w_q_next       = r_q;
      w_q_valid_next = r_q_valid;
    end
  end

  // Sticky overrun: set by a dropped word, cleared only by clr or reset.
  always_comb begin
    w_overrun_next = r_overrun;
    if (bus.clr) begin
      w_overrun_next = 1'b0;
    end else if (w_drop) begin
      w_overrun_next = 1'b1;
    end else begin
      w_overrun_next = r_overrun;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh      <= '0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sh      <= w_sh_next;
      r_cnt     <= w_cnt_next;
      r_q       <= w_q_next;
      r_q_valid <= w_q_valid_next;
      r_overrun <= w_overrun_next;
    end
  end

  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.overrun = r_overrun;
  assign bus.busy    = (r_cnt != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer, with MSB-first and LSB-first instances
// fed the same stimulus and checked against an arithmetic word-assembly model.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic clk;
  logic rst;

  sipo_deserializer_if #(.WIDTH(W)) if_msb ();
  sipo_deserializer_if #(.WIDTH(W)) if_lsb ();

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (if_msb)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (if_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, index 0 = MSB first, 1 = LSB first.
  int m_acc [2];
  int m_n   [2];
  int m_q   [2];
  bit m_qv  [2];
  bit m_ov  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_acc[m] = 0;
      m_n[m]   = 0;
      m_q[m]   = 0;
      m_qv[m]  = 1'b0;
      m_ov[m]  = 1'b0;
    end
  endtask

  task automatic model_edge(input int m, input bit d, input bit en, input bit c, input bit rdy);
    bit drain;
    drain = m_qv[m] && rdy;
    if (c) begin
      m_acc[m] = 0;
      m_n[m]   = 0;
      m_ov[m]  = 1'b0;
      if (drain) m_qv[m] = 1'b0;
    end else if (en) begin
      if (m == 0) m_acc[m] = m_acc[m] * 2 + int'(d);
      else        m_acc[m] = m_acc[m] + int'(d) * (1 << m_n[m]);
      m_n[m]++;
      if (m_n[m] == W) begin
        if (!m_qv[m] || rdy) begin
          m_q[m]  = m_acc[m];
          m_qv[m] = 1'b1;
        end else begin
          m_ov[m] = 1'b1;
        end
        m_acc[m] = 0;
        m_n[m]   = 0;
      end else if (drain) begin
        m_qv[m] = 1'b0;
      end
    end else if (drain) begin
      m_qv[m] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("msb_q",       32'(if_msb.q),       32'(m_q[0]));
    check("msb_q_valid", 32'(if_msb.q_valid), 32'(m_qv[0]));
    check("msb_busy",    32'(if_msb.busy),    32'(m_n[0] != 0));
    check("msb_overrun", 32'(if_msb.overrun), 32'(m_ov[0]));
    check("lsb_q",       32'(if_lsb.q),       32'(m_q[1]));
    check("lsb_q_valid", 32'(if_lsb.q_valid), 32'(m_qv[1]));
    check("lsb_busy",    32'(if_lsb.busy),    32'(m_n[1] != 0));
    check("lsb_overrun", 32'(if_lsb.overrun), 32'(m_ov[1]));
  endtask

  task automatic drive(input bit d, input bit en, input bit c, input bit rdy);
    if_msb.d = d;  if_msb.s_en = en;  if_msb.clr = c;  if_msb.q_ready = rdy;
    if_lsb.d = d;  if_lsb.s_en = en;  if_lsb.clr = c;  if_lsb.q_ready = rdy;
  endtask

  // One clock: apply inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input bit d, input bit en, input bit c, input bit rdy);
    drive(d, en, c, rdy);
    @(posedge clk);
    model_edge(0, d, en, c, rdy);
    model_edge(1, d, en, c, rdy);
    #1;
    compare_all();
  endtask

  // Sends bits w[3] first; rdy_last applies only on the edge carrying the final bit.
  task automatic send_word(input logic [3:0] w, input bit rdy, input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      step(w[3-i], 1'b1, 1'b0, (i == W-1) ? rdy_last : rdy);
    end
  endtask

  initial begin
    logic [3:0] gap_bits;
    int         sent;
    rst = 1'b0;
    model_reset();

    // Reset with random inputs toggling.
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      compare_all();
    end
    rst = 1'b1;

    // First word after reset, accepted immediately.
    send_word(4'b1011, 1'b1, 1'b1);
    check("first_word_q",  32'(if_msb.q), 32'h0000000b);
    check("first_word_qv", 32'(if_msb.q_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("first_word_qv_drop", 32'(if_msb.q_valid), 32'h0);

    // Bit order.
    send_word(4'b1000, 1'b1, 1'b1);
    check("order_msb", 32'(if_msb.q), 32'h8);
    check("order_lsb", 32'(if_lsb.q), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Gapped word then back-to-back word.
    gap_bits = 4'b1100;
    sent = 0;
    while (sent < W) begin
      if ($urandom_range(0, 1) == 1) begin
        step(gap_bits[3-sent], 1'b1, 1'b0, 1'b1);
        sent++;
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      end
    end
    check("gapped_q", 32'(if_msb.q), 32'hc);
    send_word(4'b0101, 1'b1, 1'b1);
    check("b2b_q",  32'(if_msb.q), 32'h5);
    check("b2b_qv", 32'(if_msb.q_valid), 32'h1);
    check("b2b_ov", 32'(if_msb.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Stall and overrun.
    send_word(4'b1111, 1'b0, 1'b0);
    send_word(4'b0000, 1'b0, 1'b0);
    check("stall_q",  32'(if_msb.q), 32'hf);
    check("stall_qv", 32'(if_msb.q_valid), 32'h1);
    check("stall_ov", 32'(if_msb.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("stall_drain_qv", 32'(if_msb.q_valid), 32'h0);
    check("stall_ov_sticky", 32'(if_msb.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_clears_ov", 32'(if_msb.overrun), 32'h0);

    // Completion coincident with handshake.
    send_word(4'b1010, 1'b0, 1'b0);
    send_word(4'b0011, 1'b0, 1'b1);
    check("coinc_q",  32'(if_msb.q), 32'h3);
    check("coinc_qv", 32'(if_msb.q_valid), 32'h1);
    check("coinc_ov", 32'(if_msb.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // clr mid-word discards the partial word and the bit on the clr edge.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_busy", 32'(if_msb.busy), 32'h0);
    send_word(4'b0110, 1'b1, 1'b1);
    check("clr_word_q", 32'(if_msb.q), 32'h6);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Pending word survives clr.
    send_word(4'b1001, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("pend_q",  32'(if_msb.q), 32'h9);
    check("pend_qv", 32'(if_msb.q_valid), 32'h1);

    // Asynchronous reset mid-word with a pending word.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 99) < 45));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
